// File: rtl/alu_pkg.sv
// Purpose : shared constants and types for the ALU sequencing front end and its decoder.
// Latency : n/a (declarations only).
// Backpr. : n/a. Contents change with ALU_MUL_EN (adds the multiply FSM state).
package alu_pkg;

  // ALU control codes driven onto alu_ctl
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  // ALUOp encodings from the main control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // ld/sd address add
  localparam logic [1:0] ALUOP_SUB   = 2'b01;  // beq compare
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // decode from funct fields
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  // funct7 / funct3 values recognised for R-type
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_OR     = 3'b110;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd3
  } state_e;
`endif

endpackage

// File: rtl/alu_ctl_decode.sv
// Purpose : ALUOp/funct7/funct3 -> {4-bit ALU ctl, is_mul, err}; also used by the single-cycle control path.
// Latency : combinational.
// Backpr. : none (no state). Mul decode exists only with ALU_MUL_EN, otherwise funct7=0000001 is an error.
// Ports   : alu_op_i[1:0], funct7_i[6:0], funct3_i[2:0] in; ctl_o[3:0], is_mul_o, err_o out.
module alu_ctl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [6:0] funct7_i,
  input  logic [2:0] funct3_i,
  output logic [3:0] ctl_o,
  output logic       is_mul_o,
  output logic       err_o
);

  always_comb begin
    ctl_o    = ALU_ADD;
    is_mul_o = 1'b0;
    err_o    = 1'b0;
    case (alu_op_i)
      ALUOP_ADD: ctl_o = ALU_ADD;
      ALUOP_SUB: ctl_o = ALU_SUB;
      ALUOP_RTYPE: begin
        case ({funct7_i, funct3_i})
          {F7_BASE, F3_ADDSUB}: ctl_o = ALU_ADD;
          {F7_ALT,  F3_ADDSUB}: ctl_o = ALU_SUB;
          {F7_BASE, F3_AND}:    ctl_o = ALU_AND;
          {F7_BASE, F3_OR}:     ctl_o = ALU_OR;
`ifdef ALU_MUL_EN
          // mul is sequenced as repeated adds, so the ALU only ever sees ADD
          {F7_MULDIV, F3_ADDSUB}: begin
            ctl_o    = ALU_ADD;
            is_mul_o = 1'b1;
          end
`endif
          default: err_o = 1'b1;
        endcase
      end
      default: err_o = 1'b1;  // ALUOP_ILL
    endcase
  end

endmodule

// File: rtl/alu_driver.sv
// Purpose : sequences one op at a time onto the external combinational 64-bit ALU; optional MUL (ALU_MUL_EN) by shift-and-add.
// Latency : accept->out_valid 2 cycles (add/sub/and/or), 1 (decode error), 65 (mul).
// Backpr. : in_ready only in IDLE; DONE holds out_* stable until out_ready.
// Ports   : clk, reset (sync, active-high); in_valid/in_ready + alu_op, funct7, funct3, a, b request;
//           alu_ctl, alu_op1, alu_op2 to the ALU, alu_result from it; out_valid/out_ready + out_result, out_zero, out_err response.
module alu_driver
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [6:0]       funct7,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_err
);

  // Only the 64-bit / 64-step configuration is meaningful.
  if (WIDTH != 64 || (1 << CNT_W) != WIDTH) begin : g_cfg_check
    $error("alu_driver: only WIDTH=64 with CNT_W=6 is supported");
  end

  logic [3:0] dec_ctl;
  logic       dec_is_mul;
  logic       dec_err;
  logic       dec_bad;

  alu_ctl_decode u_dec (
    .alu_op_i (alu_op),
    .funct7_i (funct7),
    .funct3_i (funct3),
    .ctl_o    (dec_ctl),
    .is_mul_o (dec_is_mul),
    .err_o    (dec_err)
  );

`ifdef ALU_MUL_EN
  assign dec_bad = dec_err;
`else
  // No multiplier in this build; a mul flag can never be honoured here.
  assign dec_bad = dec_err | dec_is_mul;
`endif

  state_e           state_q, state_d;
  logic [3:0]       ctl_q, ctl_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

`ifdef ALU_MUL_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_step;

  // acc after this step: ALU computes acc + mcand, kept only when the multiplier bit is set
  assign acc_step = mplier_q[0] ? alu_result : acc_q;
`endif

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    ctl_d   = ctl_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;
`ifdef ALU_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          ctl_d = dec_ctl;
          a_d   = a;
          b_d   = b;
`ifdef ALU_MUL_EN
          acc_d    = '0;
          mcand_d  = a;
          mplier_d = b;
          cnt_d    = '0;
`endif
          if (dec_bad) begin
            err_d   = 1'b1;
            res_d   = '0;
            zero_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            err_d = 1'b0;
`ifdef ALU_MUL_EN
            state_d = dec_is_mul ? ST_MUL : ST_EXEC;
`else
            state_d = ST_EXEC;
`endif
          end
        end
      end
      ST_EXEC: begin
        res_d   = alu_result;
        zero_d  = (alu_result == '0);
        state_d = ST_DONE;
      end
`ifdef ALU_MUL_EN
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // fixed 64 steps, no early exit on an exhausted multiplier
        if (cnt_q == CNT_LAST) begin
          res_d   = acc_step;
          zero_d  = (acc_step == '0);
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ctl_q   <= ALU_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
`ifdef ALU_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  // ALU-facing drive: idle value is ADD of zeros so the ALU inputs are quiet
  always_comb begin
    alu_ctl = ALU_ADD;
    alu_op1 = '0;
    alu_op2 = '0;
    case (state_q)
      ST_EXEC: begin
        alu_ctl = ctl_q;
        alu_op1 = a_q;
        alu_op2 = b_q;
      end
`ifdef ALU_MUL_EN
      ST_MUL: begin
        alu_ctl = ALU_ADD;
        alu_op1 = acc_q;
        alu_op2 = mcand_q;
      end
`endif
      default: ;
    endcase
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = res_q;
  assign out_zero   = zero_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_alu_driver.sv
module tb_alu_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = 2'b00;
  logic [6:0]  funct7 = 7'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [63:0] a = 64'd0;
  logic [63:0] b = 64'd0;
  logic [3:0]  alu_ctl;
  logic [63:0] alu_op1;
  logic [63:0] alu_op2;
  logic [63:0] alu_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic        out_zero;
  logic        out_err;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit run = 1'b0;

  alu_driver dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .a(a), .b(b),
    .alu_ctl(alu_ctl), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The external combinational ALU
  always_comb begin
    case (alu_ctl)
      4'b0010: alu_result = alu_op1 + alu_op2;
      4'b0110: alu_result = alu_op1 - alu_op2;
      4'b0000: alu_result = alu_op1 & alu_op2;
      4'b0001: alu_result = alu_op1 | alu_op2;
      default: alu_result = 64'd0;
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: what a request must produce, straight from the op table
  function automatic void model(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                                input logic [63:0] av, input logic [63:0] bv,
                                output bit err, output bit mul, output logic [3:0] ctl,
                                output logic [63:0] res);
    err = 0; mul = 0; ctl = 4'b0010; res = 64'd0;
    if (op == 2'b00) res = av + bv;
    else if (op == 2'b01) begin ctl = 4'b0110; res = av - bv; end
    else if (op == 2'b10) begin
      if (f7 == 7'b0000000 && f3 == 3'b000) res = av + bv;
      else if (f7 == 7'b0100000 && f3 == 3'b000) begin ctl = 4'b0110; res = av - bv; end
      else if (f7 == 7'b0000000 && f3 == 3'b111) begin ctl = 4'b0000; res = av & bv; end
      else if (f7 == 7'b0000000 && f3 == 3'b110) begin ctl = 4'b0001; res = av | bv; end
      else if (MUL_EN && f7 == 7'b0000001 && f3 == 3'b000) begin mul = 1; res = av * bv; end
      else err = 1;
    end else err = 1;
    if (err) res = 64'd0;
  endfunction

  // Per-cycle compare against the model
  bit          pend = 0;
  int          acc_cyc, vcyc;
  bit          e_err, e_mul, exp_v;
  logic [3:0]  e_ctl;
  logic [63:0] e_res, e_a, e_b, mask;
  int          k;

  always @(negedge clk) begin
    if (run) begin
      exp_v = pend && (cyc >= vcyc);
      chk("in_ready", 64'(in_ready), 64'(!pend));
      chk("out_valid", 64'(out_valid), 64'(exp_v));
      if (exp_v) begin
        chk("out_result", out_result, e_res);
        chk("out_zero", 64'(out_zero), 64'(!e_err && e_res == 64'd0));
        chk("out_err", 64'(out_err), 64'(e_err));
      end
      if (pend && !e_err && !e_mul && cyc == acc_cyc + 1) begin
        chk("exec_ctl", 64'(alu_ctl), 64'(e_ctl));
        chk("exec_op1", alu_op1, e_a);
        chk("exec_op2", alu_op2, e_b);
      end else if (pend && e_mul && cyc < vcyc) begin
        // step k: accumulator holds a * (low k bits of b), addend is a << k
        k = cyc - acc_cyc - 1;
        mask = (64'd1 << k) - 64'd1;
        chk("mul_ctl", 64'(alu_ctl), 64'h2);
        chk("mul_op1", alu_op1, e_a * (e_b & mask));
        chk("mul_op2", alu_op2, e_a << k);
      end else begin
        chk("idle_ctl", 64'(alu_ctl), 64'h2);
        chk("idle_op1", alu_op1, 64'd0);
        chk("idle_op2", alu_op2, 64'd0);
      end
      if (reset) pend = 0;
      else if (exp_v && out_ready) pend = 0;
      else if (!pend && in_valid) begin
        model(alu_op, funct7, funct3, a, b, e_err, e_mul, e_ctl, e_res);
        e_a = a; e_b = b;
        acc_cyc = cyc;
        vcyc = cyc + (e_err ? 1 : (e_mul ? 65 : 2));
        pend = 1;
      end
    end
  end

  int t_acc;

  task automatic issue(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [63:0] av, input logic [63:0] bv);
    int n;
    @(posedge clk); #1;
    in_valid = 1; alu_op = op; funct7 = f7; funct3 = f3; a = av; b = bv;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end
    t_acc = cyc;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_valid(output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL valid_timeout: out_valid stayed 0, required 1");
      lat = -1;
    end else lat = cyc - t_acc;
  endtask

  task automatic release_out();
    @(posedge clk); #1; out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [63:0] av, input logic [63:0] bv,
                        input logic [63:0] xr, input bit xz, input bit xe, input int xl);
    int lat;
    issue(op, f7, f3, av, bv);
    wait_valid(lat);
    chk({nm, "_result"}, out_result, xr);
    chk({nm, "_zero"}, 64'(out_zero), 64'(xz));
    chk({nm, "_err"}, 64'(out_err), 64'(xe));
    chk({nm, "_latency"}, 64'(lat), 64'(xl));
    release_out();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, seen;
    repeat (3) @(posedge clk);
    #1; reset = 0; run = 1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_zero", 64'(out_zero), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_alu_ctl", 64'(alu_ctl), 64'h2);
    chk("rst_alu_op1", alu_op1, 64'd0);

    run_op("add",  2'b00, 7'h00, 3'b000, 64'd5, 64'd7, 64'd12, 0, 0, 2);
    run_op("beq",  2'b01, 7'h00, 3'b000, 64'h1234, 64'h1234, 64'd0, 1, 0, 2);
    run_op("rsub", 2'b10, 7'h20, 3'b000, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 2);
    run_op("rand", 2'b10, 7'h00, 3'b111, 64'hF0F0, 64'h0FF0, 64'h00F0, 0, 0, 2);
    run_op("ror",  2'b10, 7'h00, 3'b110, 64'hF0F0, 64'h0FF0, 64'hFFF0, 0, 0, 2);
    run_op("radd", 2'b10, 7'h00, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 0, 0, 2);
    run_op("ill",  2'b11, 7'h00, 3'b000, 64'd9, 64'd9, 64'd0, 0, 1, 1);
    run_op("f3bad", 2'b10, 7'h00, 3'b001, 64'd9, 64'd9, 64'd0, 0, 1, 1);
    // out_err must clear on the next good request
    run_op("after_err", 2'b00, 7'h00, 3'b000, 64'd1, 64'd2, 64'd3, 0, 0, 2);
`ifdef ALU_MUL_EN
    run_op("mul3", 2'b10, 7'h01, 3'b000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 65);
    run_op("mul0", 2'b10, 7'h01, 3'b000, 64'd0, 64'd12345, 64'd0, 1, 0, 65);
    run_op("mulx", 2'b10, 7'h01, 3'b000, 64'h1_0000_0001, 64'h1_0000_0003, 64'h4_0000_0003, 0, 0, 65);
`else
    run_op("nomul", 2'b10, 7'h01, 3'b000, 64'd6, 64'd7, 64'd0, 0, 1, 1);
`endif

    // Backpressure: response held for 10 cycles
    issue(2'b00, 7'h00, 3'b000, 64'd100, 64'd23);
    wait_valid(lat);
    repeat (10) @(negedge clk);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_out_result", out_result, 64'd123);
    release_out();

    // Reset while a response is pending in DONE
    issue(2'b00, 7'h00, 3'b000, 64'd40, 64'd2);
    wait_valid(lat);
    @(posedge clk); #1; reset = 1;
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    chk("rst_done_valid", 64'(out_valid), 64'd0);
    chk("rst_done_result", out_result, 64'd0);
    chk("rst_done_ready", 64'(in_ready), 64'd1);

`ifdef ALU_MUL_EN
    // Reset during the 30th multiply step: no response must ever appear
    issue(2'b10, 7'h01, 3'b000, 64'd77, 64'd99);
    repeat (29) @(posedge clk);
    #1; reset = 1;
    @(posedge clk); #1; reset = 0;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_mul_no_valid", 64'(seen), 64'd0);
    chk("rst_mul_ready", 64'(in_ready), 64'd1);
`endif

    run_op("final", 2'b01, 7'h00, 3'b000, 64'd10, 64'd3, 64'd7, 0, 0, 2);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_driver.md
# alu_driver

Sequencing front end that sits between the datapath issue logic and the 64-bit combinational ALU. It accepts an operation with a valid/ready handshake and decodes the ALUOp/funct fields into the 4-bit ALU control code. It drives the ALU operand and control inputs, samples the ALU result, and returns it with a locally computed zero flag through a second valid/ready handshake. With the optional multiply path enabled, it implements MUL as a 64-step shift-and-add loop that reuses the ALU's add operation.

## Interface
- Clock/reset: one clock `clk`; reset `reset` is synchronous and active-high.
- Parameters:
  - `WIDTH`, 64, datapath width. Only 64 is supported.
  - `CNT_W`, 6, multiply iteration counter width.
- Ports:
  - `clk` in 1: clock.
  - `reset` in 1: synchronous, active-high reset.
  - `in_valid` in 1: request valid.
  - `in_ready` out 1: driver can accept a request.
  - `alu_op` in 2: ALUOp. 00 = add (ld/sd), 01 = sub (beq), 10 = R-type, 11 = illegal.
  - `funct7` in 7, `funct3` in 3: R-type function fields.
  - `a` in WIDTH, `b` in WIDTH: source operands.
  - `alu_ctl` out 4: ALU control code. 0010 add, 0110 sub, 0000 and, 0001 or.
  - `alu_op1` out WIDTH, `alu_op2` out WIDTH: ALU operands.
  - `alu_result` in WIDTH: combinational ALU result.
  - `out_valid` out 1: response valid.
  - `out_ready` in 1: consumer accepts the response.
  - `out_result` out WIDTH: result.
  - `out_zero` out 1: asserted when `out_result` equals 0.
  - `out_err` out 1: the request did not decode.

## Operation
- Decode:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10 with {funct7, funct3}:
    - {0000000, 000} -> add
    - {0100000, 000} -> sub
    - {0000000, 111} -> and
    - {0000000, 110} -> or
    - {0000001, 000} -> mul (only with `ALU_MUL_EN`)
  - Any other encoding -> error.
- FSM states: IDLE, EXEC, MUL, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`, the driver latches the operands and the decoded ctl.
  - Decoded op is add/sub/and/or -> EXEC.
  - Decoded op is mul -> MUL.
  - Decode error -> DONE with `out_err` = 1, `out_result` = 0, `out_zero` = 0.
- EXEC (1 cycle):
  - Drives `alu_ctl`, `alu_op1` = a, `alu_op2` = b.
  - At the clock edge, `out_result` <= `alu_result` and `out_zero` <= (`alu_result` == 0).
  - Next state: DONE.
- MUL (64 cycles):
  - Initial values: acc = 0, mcand = a, mplier = b, cnt = 0.
  - Each cycle drives `alu_ctl` = add, `alu_op1` = acc, `alu_op2` = mcand.
  - At the clock edge:
    - if mplier[0] = 1, acc <= `alu_result`
    - mcand <<= 1
    - mplier >>= 1
    - cnt++
  - When cnt = 63, the edge writes the final acc to `out_result`, sets `out_zero`, and moves to DONE.
  - The product is truncated to its low 64 bits; there is no early exit.
- DONE:
  - `out_valid` = 1; all `out_*` held stable.
  - On `out_ready` -> IDLE.
- The ALU zero flag is not consumed. `out_zero` is always computed locally from the sampled 64-bit value.
- Arithmetic wraps modulo 2^64. No overflow flag.
- The ALU-facing outputs are a combinational function of state and internal registers. In IDLE and DONE they are `alu_ctl` = 0010, `alu_op1` = `alu_op2` = 0.

## Timing
- Reset values:
  - state = IDLE, `in_ready` = 1
  - `out_valid` = 0, `out_result` = 0, `out_zero` = 0, `out_err` = 0
  - `alu_ctl` = 0010, `alu_op1` = `alu_op2` = 0
- Latency is counted from the accept edge to the first cycle with `out_valid` high:
  - add/sub/and/or: 2 cycles.
  - decode error: 1 cycle.
  - mul: 65 cycles.
- Handshake rules:
  - Accept occurs when `in_valid` && `in_ready`.
  - Response completes when `out_valid` && `out_ready`.
  - `in_ready` = 0 in EXEC, MUL and DONE. One operation is in flight at a time; a request held during a response is taken in the cycle after DONE exits.
  - Peak throughput: one ALU op per 3 cycles.
- `out_ready` held low keeps DONE and the output values indefinitely.
- Reset asserted in any state returns the FSM to IDLE at the next edge. The in-flight operation is discarded and no `out_valid` is produced.
- `out_err` clears on the next accepted request.

## Configuration
- Macro: `ALU_MUL_EN`.
- Defined: the MUL state, the acc/mcand/mplier/cnt registers and the mul decode are present.
- Undefined: none of those exist, funct7 = 0000001 decodes as error, and the FSM has only IDLE, EXEC and DONE.

## Structure
- Package `alu_pkg`:
  - ALU ctl constants ALU_ADD/ALU_SUB/ALU_AND/ALU_OR
  - ALUOp encodings
  - FSM state typedef
  - funct7 constants
- Sub-module `alu_ctl_decode`: combinational ALUOp/funct7/funct3 -> {ctl, is_mul, err}. It is shared with the single-cycle control path.

## Test plan
- ALUOp 00, a = 5, b = 7 -> `alu_ctl` = 0010 in EXEC; `out_result` = 12, `out_zero` = 0, `out_valid` 2 cycles after accept.
- ALUOp 01, a = b = 0x1234 -> `alu_ctl` = 0110; `out_result` = 0, `out_zero` = 1.
- R-type sub with a = 0, b = 1 -> `out_result` = 0xFFFF_FFFF_FFFF_FFFF (wrap). R-type and/or with a = 0xF0F0, b = 0x0FF0 -> 0x00F0 and 0xFFF0.
- ALUOp 11, and R-type funct3 = 001 -> `out_err` = 1, `out_result` = 0, latency 1. Without `ALU_MUL_EN`, funct7 = 0000001 -> `out_err` = 1.
- With `ALU_MUL_EN`:
  - a = 3, b = 0xFFFF_FFFF_FFFF_FFFF -> `out_result` = 0xFFFF_FFFF_FFFF_FFFD at 65 cycles.
  - a = 0 -> `out_zero` = 1.
- Backpressure and reset:
  - `out_ready` low for 10 cycles -> `out_*` stable and `in_ready` = 0.
  - Reset pulse at MUL cycle 30 -> IDLE next edge, no `out_valid`.
